micro_sequencer: RTL and testbench
==================================

Name: micro_sequencer

Overview:
Next-micro-address sequencer for the microprogrammed controller. It holds the current micro-PC register and drives it to the control store and to the existing +1 incrementer. Each cycle it selects the next micro-address from one of four sources: the incrementer result, a branch field, a dispatch address, or a small return stack. It also runs a run/idle/fault state machine.

Parameters:
AW, 4, micro-address width; must match the incrementer width.
STACK_DEPTH, 2, number of micro-subroutine return entries (1..4).
RESET_ADDR, 0, micro-address loaded on reset and on HALT.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  leave IDLE and begin execution.
stall  input  1  freeze sequencing this cycle, e.g. memory not ready.
seq_op  input  3  sequencing op from the current microinstruction.
branch_addr  input  AW  target field from the current microinstruction.
cond  input  1  selected condition flag from the datapath.
dispatch_addr  input  AW  opcode-mapped entry address from the dispatch ROM.
mpc_plus_1  input  AW  current_mpc+1 from the incrementer; wraps 15->0.
current_mpc  output  AW  micro-PC register; feeds the control store and the incrementer.
running  output  1  high in RUN.
fault  output  1  high in FAULT; sticky until reset.
stack_empty  output  1  high when the return stack holds 0 entries.

Behaviour:
- All outputs and internal state are registered. No combinational path exists from inputs to outputs.
- Reset (rst_n=0, asynchronous) sets: current_mpc=RESET_ADDR, state=IDLE, sp=0, running=0, fault=0, stack_empty=1.
- Reset mid-operation aborts immediately and clears the stack. Deassertion is synchronous to clk by the system reset bridge.
- States: IDLE, RUN, FAULT.
- IDLE: current_mpc holds. start=1 -> RUN on the next edge, with current_mpc unchanged (RESET_ADDR executes first). seq_op, stall and cond are ignored.
- RUN with stall=1: no register changes. Stall has priority over every seq_op, including HALT.
- RUN with stall=0: seq_op is decoded; the next current_mpc is:
  - 0 NEXT: mpc_plus_1.
  - 1 JUMP: branch_addr.
  - 2 BRT: branch_addr if cond=1, else mpc_plus_1.
  - 3 BRF: branch_addr if cond=0, else mpc_plus_1.
  - 4 DISPATCH: dispatch_addr.
  - 5 CALL: push mpc_plus_1, then go to branch_addr. If the stack is full (sp=STACK_DEPTH) -> FAULT; current_mpc and the stack are unchanged.
  - 6 RET: pop the top entry into current_mpc. If the stack is empty -> FAULT; current_mpc is unchanged.
  - 7 HALT: current_mpc=RESET_ADDR, stack cleared (sp=0), state -> IDLE.
- Latency: the next address appears on current_mpc one clock after the op is presented.
- Wrap-around: mpc_plus_1 is used verbatim. NEXT at address 15 goes to 0 with no fault. A CALL at 15 pushes 0.
- FAULT: all registers frozen, fault=1, running=0. Only rst_n exits FAULT; start is ignored.
- start in RUN or FAULT has no effect.
- cond and branch_addr are sampled only on the cycle their op executes.
- The stack is LIFO. Entries beyond sp are don't-care and are not observable.

Decomposition:
- Shared package micro_seq_pkg holds:
  - seq_op encodings SEQ_NEXT..SEQ_HALT (3'd0..3'd7).
  - State encodings ST_IDLE, ST_RUN, ST_FAULT.
  - Default AW.
- One sub-module, micro_ret_stack: STACK_DEPTH x AW register file with push, pop, top, full and empty signals, and a synchronous clear. Full/empty are decided inside it. The sequencer owns the FSM and the next-address mux.

Test Plan:
- Reset, then start, then NEXT x3: current_mpc goes 0,0,1,2,3; running rises one cycle after start.
- BRT with cond=0 at mpc 3, then cond=1 with branch_addr=9 at mpc 4: mpc goes 4, then 9. BRF is mirrored the same way.
- NEXT at mpc 15 gives 0. CALL at mpc 15 with branch_addr=6 gives mpc 6, stack_empty=0; a RET then gives 0 and stack_empty=1.
- Nested CALL x2 (depth 2) followed by a third CALL: fault=1 and mpc holds. A later start, and any stall, produce no change until rst_n.
- RET at an empty stack: fault=1 and mpc holds. A stall asserted during JUMP or HALT freezes the mpc until stall drops. HALT then gives mpc=0, IDLE, running=0.
- rst_n pulsed low between clock edges mid-CALL-sequence: outputs reset immediately, without waiting for clk.

Source files
------------

// File: rtl/micro_seq_pkg.sv
// Shared encodings for the micro-sequencer: seq_op values, FSM states and
// the default micro-address width.
package micro_seq_pkg;

  localparam int unsigned DEFAULT_AW = 4;

  typedef enum logic [2:0] {
    SEQ_NEXT     = 3'd0,
    SEQ_JUMP     = 3'd1,
    SEQ_BRT      = 3'd2,
    SEQ_BRF      = 3'd3,
    SEQ_DISPATCH = 3'd4,
    SEQ_CALL     = 3'd5,
    SEQ_RET      = 3'd6,
    SEQ_HALT     = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/micro_ret_stack.sv
// LIFO return-address stack for micro-subroutines with synchronous clear.
// The caller only asserts push when !full and pop when !empty.
module micro_ret_stack
  import micro_seq_pkg::*;
#(
  parameter int unsigned AW          = DEFAULT_AW,
  parameter int unsigned STACK_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH + 1);

  logic [SPW-1:0] sp;
  logic [AW-1:0]  mem [STACK_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp - SPW'(1);
    end
  end

  // Entry storage needs no reset: slots at or above sp are never read.
  always_ff @(posedge clk) begin
    if (!clear && push && !full) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
        if (sp == SPW'(i)) mem[i] <= push_data;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (sp == SPW'(i + 1)) top = mem[i];
    end
  end

  assign full  = (sp == SPW'(STACK_DEPTH));
  assign empty = (sp == '0);

endmodule

// File: rtl/micro_sequencer.sv
// Next-micro-address sequencer: micro-PC register, four-source next-address
// selection, return stack and a run/idle/fault state machine.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int unsigned   AW          = DEFAULT_AW,
  parameter int unsigned   STACK_DEPTH = 2,
  parameter logic [AW-1:0] RESET_ADDR  = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stall,
  input  logic [2:0]    seq_op,
  input  logic [AW-1:0] branch_addr,
  input  logic          cond,
  input  logic [AW-1:0] dispatch_addr,
  input  logic [AW-1:0] mpc_plus_1,
  output logic [AW-1:0] current_mpc,
  output logic          running,
  output logic          fault,
  output logic          stack_empty
);

  state_e        state;
  seq_op_e       op;
  logic          stk_push, stk_pop, stk_clear;
  logic          stk_full, stk_empty;
  logic [AW-1:0] stk_top;
  logic          exec;

  assign op   = seq_op_e'(seq_op);
  assign exec = (state == ST_RUN) && !stall;

  always_comb begin
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clear = 1'b0;
    if (exec) begin
      case (op)
        SEQ_CALL: stk_push  = !stk_full;
        SEQ_RET:  stk_pop   = !stk_empty;
        SEQ_HALT: stk_clear = 1'b1;
        default:  ;
      endcase
    end
  end

  micro_ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (mpc_plus_1),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign stack_empty = stk_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      current_mpc <= RESET_ADDR;
      running     <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!stall) begin
            case (op)
              SEQ_NEXT:     current_mpc <= mpc_plus_1;
              SEQ_JUMP:     current_mpc <= branch_addr;
              SEQ_BRT:      current_mpc <= cond ? branch_addr : mpc_plus_1;
              SEQ_BRF:      current_mpc <= cond ? mpc_plus_1 : branch_addr;
              SEQ_DISPATCH: current_mpc <= dispatch_addr;
              SEQ_CALL: begin
                if (stk_full) begin
                  state   <= ST_FAULT;
                  running <= 1'b0;
                  fault   <= 1'b1;
                end else begin
                  current_mpc <= branch_addr;
                end
              end
              SEQ_RET: begin
                if (stk_empty) begin
                  state   <= ST_FAULT;
                  running <= 1'b0;
                  fault   <= 1'b1;
                end else begin
                  current_mpc <= stk_top;
                end
              end
              SEQ_HALT: begin
                current_mpc <= RESET_ADDR;
                state       <= ST_IDLE;
                running     <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a vector table walked in order plus
// hand-written overflow and asynchronous-reset sequences.
module tb_micro_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stall, cond;
  logic [2:0] seq_op;
  logic [3:0] branch_addr, dispatch_addr, mpc_plus_1, current_mpc;
  logic       running, fault, stack_empty;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the external incrementer (wraps 15->0).
  assign mpc_plus_1 = current_mpc + 4'd1;

  micro_sequencer #(
    .AW          (4),
    .STACK_DEPTH (2),
    .RESET_ADDR  (4'd0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .seq_op        (seq_op),
    .branch_addr   (branch_addr),
    .cond          (cond),
    .dispatch_addr (dispatch_addr),
    .mpc_plus_1    (mpc_plus_1),
    .current_mpc   (current_mpc),
    .running       (running),
    .fault         (fault),
    .stack_empty   (stack_empty)
  );

  typedef struct {
    logic       start;
    logic       stall;
    logic [2:0] op;
    logic [3:0] br;
    logic       cond;
    logic [3:0] disp;
    logic [3:0] exp_mpc;
    logic       exp_run;
    logic       exp_fault;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, BRT = 3'd2, BRF = 3'd3,
                         DISP = 3'd4, CALL = 3'd5, RET = 3'd6, HALT = 3'd7;

  task automatic add(input logic st, input logic sl, input logic [2:0] op,
                     input logic [3:0] br, input logic c, input logic [3:0] d,
                     input logic [3:0] m, input logic r, input logic f,
                     input logic e);
    vec_t v;
    v.start = st; v.stall = sl; v.op = op; v.br = br; v.cond = c; v.disp = d;
    v.exp_mpc = m; v.exp_run = r; v.exp_fault = f; v.exp_empty = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [3:0] m, input logic r,
                       input logic f, input logic e);
    checks++;
    if (current_mpc !== m) begin
      errors++;
      $display("FAIL %s mpc: got %0d expected %0d", nm, current_mpc, m);
    end
    checks++;
    if (running !== r) begin
      errors++;
      $display("FAIL %s running: got %b expected %b", nm, running, r);
    end
    checks++;
    if (fault !== f) begin
      errors++;
      $display("FAIL %s fault: got %b expected %b", nm, fault, f);
    end
    checks++;
    if (stack_empty !== e) begin
      errors++;
      $display("FAIL %s stack_empty: got %b expected %b", nm, stack_empty, e);
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic [2:0] op,
                       input logic [3:0] br, input logic c, input logic [3:0] d);
    @(negedge clk);
    start = st; stall = sl; seq_op = op; branch_addr = br; cond = c;
    dispatch_addr = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; seq_op = NEXT; branch_addr = '0; cond = 1'b0;
    dispatch_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0; stall = 1'b0; seq_op = NEXT; branch_addr = '0; cond = 1'b0;
    dispatch_addr = '0;

    //  st sl op    br     c  disp   mpc    run f  empty
    add(1, 0, NEXT, 4'd0,  0, 4'd0,  4'd0,  1, 0, 1); // start; op ignored
    add(0, 0, NEXT, 4'd0,  0, 4'd0,  4'd1,  1, 0, 1);
    add(0, 0, NEXT, 4'd0,  0, 4'd0,  4'd2,  1, 0, 1);
    add(0, 0, NEXT, 4'd0,  0, 4'd0,  4'd3,  1, 0, 1);
    add(0, 0, BRT,  4'd9,  0, 4'd0,  4'd4,  1, 0, 1);
    add(0, 0, BRT,  4'd9,  1, 4'd0,  4'd9,  1, 0, 1);
    add(0, 0, BRF,  4'd2,  1, 4'd0,  4'd10, 1, 0, 1);
    add(0, 0, BRF,  4'd2,  0, 4'd0,  4'd2,  1, 0, 1);
    add(0, 0, DISP, 4'd0,  0, 4'd14, 4'd14, 1, 0, 1);
    add(0, 0, NEXT, 4'd0,  0, 4'd0,  4'd15, 1, 0, 1);
    add(0, 0, NEXT, 4'd0,  0, 4'd0,  4'd0,  1, 0, 1); // wrap
    add(0, 0, JUMP, 4'd15, 0, 4'd0,  4'd15, 1, 0, 1);
    add(0, 0, CALL, 4'd6,  0, 4'd0,  4'd6,  1, 0, 0); // pushes 0
    add(0, 0, RET,  4'd0,  0, 4'd0,  4'd0,  1, 0, 1);
    add(0, 1, JUMP, 4'd5,  0, 4'd0,  4'd0,  1, 0, 1); // stalled
    add(0, 0, JUMP, 4'd5,  0, 4'd0,  4'd5,  1, 0, 1);
    add(0, 0, CALL, 4'd8,  0, 4'd0,  4'd8,  1, 0, 0); // push 6
    add(0, 0, CALL, 4'd12, 0, 4'd0,  4'd12, 1, 0, 0); // push 9
    add(0, 0, RET,  4'd0,  0, 4'd0,  4'd9,  1, 0, 0);
    add(0, 0, RET,  4'd0,  0, 4'd0,  4'd6,  1, 0, 1);
    add(0, 1, DISP, 4'd0,  0, 4'd3,  4'd6,  1, 0, 1);
    add(0, 1, HALT, 4'd0,  0, 4'd0,  4'd6,  1, 0, 1); // stall beats HALT
    add(0, 0, HALT, 4'd0,  0, 4'd0,  4'd0,  0, 0, 1);
    add(0, 0, JUMP, 4'd7,  1, 4'd0,  4'd0,  0, 0, 1); // idle ignores op
    add(1, 0, JUMP, 4'd7,  0, 4'd0,  4'd0,  1, 0, 1);
    add(0, 0, CALL, 4'd4,  0, 4'd0,  4'd4,  1, 0, 0);
    add(0, 0, HALT, 4'd0,  0, 4'd0,  4'd0,  0, 0, 1); // clears stack
    add(1, 0, NEXT, 4'd0,  0, 4'd0,  4'd0,  1, 0, 1);
    add(0, 0, RET,  4'd0,  0, 4'd0,  4'd0,  0, 1, 1); // underflow
    add(1, 0, NEXT, 4'd0,  0, 4'd0,  4'd0,  0, 1, 1);
    add(0, 1, JUMP, 4'd3,  0, 4'd0,  4'd0,  0, 1, 1);

    do_reset();
    check("reset", 4'd0, 1'b0, 1'b0, 1'b1);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].op, vecs[i].br,
            vecs[i].cond, vecs[i].disp);
      check($sformatf("vec%0d", i), vecs[i].exp_mpc, vecs[i].exp_run,
            vecs[i].exp_fault, vecs[i].exp_empty);
    end

    // Stack overflow: third nested CALL faults and freezes everything.
    do_reset();
    drive(1, 0, NEXT, 4'd0, 0, 4'd0);
    check("ovf_start", 4'd0, 1'b1, 1'b0, 1'b1);
    drive(0, 0, CALL, 4'd5, 0, 4'd0);
    check("ovf_call1", 4'd5, 1'b1, 1'b0, 1'b0);
    drive(0, 0, CALL, 4'd10, 0, 4'd0);
    check("ovf_call2", 4'd10, 1'b1, 1'b0, 1'b0);
    drive(0, 0, CALL, 4'd3, 0, 4'd0);
    check("ovf_call3", 4'd10, 1'b0, 1'b1, 1'b0);
    drive(1, 0, RET, 4'd0, 0, 4'd0);
    check("ovf_start_ign", 4'd10, 1'b0, 1'b1, 1'b0);
    drive(0, 1, HALT, 4'd0, 0, 4'd0);
    check("ovf_stall_ign", 4'd10, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset between clock edges mid-CALL sequence.
    do_reset();
    check("arst_clear", 4'd0, 1'b0, 1'b0, 1'b1);
    drive(1, 0, NEXT, 4'd0, 0, 4'd0);
    drive(0, 0, CALL, 4'd7, 0, 4'd0);
    check("arst_call", 4'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    seq_op = CALL; branch_addr = 4'd11;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_async", 4'd0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0; seq_op = NEXT;
    @(posedge clk);
    #1;
    check("arst_idle", 4'd0, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
